// File: rtl/div.sv
// Signed 32-bit sequential divider: restoring shift-subtract on magnitudes,
// sign correction in FIX, quotient on low and remainder on hi.
module div (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_A_Dd,
    input  logic [31:0] value_B_Dv,
    input  logic        divInit,
    output logic [31:0] hi,
    output logic [31:0] low,
    output logic        divBusy,
    output logic        divDone,
    output logic        divZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] low_q, low_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_q_q, sign_q_d;
    logic        zero_q, zero_d;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] part_rem;
    logic [32:0] trial;

    // Operand magnitudes and one restoring step on the 33-bit partial remainder.
    always_comb begin
        abs_a    = value_A_Dd[31] ? (~value_A_Dd + 32'd1) : value_A_Dd;
        abs_b    = value_B_Dv[31] ? (~value_B_Dv + 32'd1) : value_B_Dv;
        part_rem = {rem_q, quo_q[31]};
        trial    = part_rem - {1'b0, dvsr_q};
    end

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        hi_d     = hi_q;
        low_d    = low_q;
        sign_a_d = sign_a_q;
        sign_q_d = sign_q_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                cnt_d = 6'd0;
                if (divInit) begin
                    rem_d    = 32'd0;
                    quo_d    = abs_a;
                    dvsr_d   = abs_b;
                    sign_a_d = value_A_Dd[31];
                    sign_q_d = value_A_Dd[31] ^ value_B_Dv[31];
                    zero_d   = 1'b0;
                    if (value_B_Dv == 32'd0) begin
                        zero_d  = 1'b1;
                        hi_d    = value_A_Dd;
                        low_d   = 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // Counts 0..31 are the 32 shift-subtract steps; count 32 is a settle cycle.
                if (!cnt_q[5]) begin
                    cnt_d = cnt_q + 6'd1;
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = part_rem[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end else begin
                    state_d = FIX;
                end
            end

            FIX: begin
                low_d   = sign_q_q ? (~quo_q + 32'd1) : quo_q;
                hi_d    = sign_a_q ? (~rem_q + 32'd1) : rem_q;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            hi_q     <= 32'd0;
            low_q    <= 32'd0;
            sign_a_q <= 1'b0;
            sign_q_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            hi_q     <= hi_d;
            low_q    <= low_d;
            sign_a_q <= sign_a_d;
            sign_q_q <= sign_q_d;
            zero_q   <= zero_d;
        end
    end

    assign hi      = hi_q;
    assign low     = low_q;
    assign divBusy = (state_q != IDLE);
    assign divDone = (state_q == DONE);
    assign divZero = zero_q;

endmodule
